// File: rtl/seq_stream_gen.sv
// Serial pattern transmitter for the y1/y2 sequence detector: shifts a latched
// pattern out on x at one bit per slow tick and counts detector hits on z.
module seq_stream_gen #(
    parameter int PATTERN_W = 8,
    parameter int TICK_DIV  = 4,
    parameter int HIT_W     = 8
) (
    input  logic                               clk,
    input  logic                               clr_n,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               repeat_en,
    input  logic [PATTERN_W-1:0]               pattern,
    input  logic [$clog2(PATTERN_W+1)-1:0]     len,
    input  logic                               z,
    output logic                               x,
    output logic                               tick_o,
    output logic                               busy,
    output logic                               done,
    output logic [HIT_W-1:0]                   hits
);

    localparam int LW = $clog2(PATTERN_W + 1);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [LW-1:0] FULL_LEN = LW'(PATTERN_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_reg;
    logic [PATTERN_W-1:0] shreg_reg;
    logic [PATTERN_W-1:0] pat_q_reg;
    logic [LW-1:0]        len_q_reg;
    logic [LW-1:0]        bit_cnt_reg;
    logic [DW-1:0]        div_reg;
    logic [HIT_W-1:0]     hits_reg;

    logic [PATTERN_W-1:0] shreg_shift;
    logic [LW-1:0]        len_clamped;
    logic                 in_send;
    logic                 tick;
    logic                 last_bit;

    assign shreg_shift[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < PATTERN_W; gi++) begin : g_shift
            assign shreg_shift[gi] = shreg_reg[gi-1];
        end
    endgenerate

    assign len_clamped = ((len == '0) || (len > FULL_LEN)) ? FULL_LEN : len;
    assign in_send     = (state_reg == ST_SEND);
    assign tick        = in_send && (div_reg == DIV_LAST);
    assign last_bit    = (bit_cnt_reg == len_q_reg - LW'(1));

    // shreg is cleared whenever SEND is left, so its MSB is a glitch-free x that idles low.
    assign x      = shreg_reg[PATTERN_W-1];
    assign tick_o = tick;
    assign busy   = in_send;
    assign done   = (state_reg == ST_DONE);
    assign hits   = hits_reg;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg   <= ST_IDLE;
            shreg_reg   <= '0;
            pat_q_reg   <= '0;
            len_q_reg   <= '0;
            bit_cnt_reg <= '0;
            div_reg     <= '0;
            hits_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    div_reg <= '0;
                    if (start && !stop) begin
                        shreg_reg   <= pattern;
                        pat_q_reg   <= pattern;
                        len_q_reg   <= len_clamped;
                        bit_cnt_reg <= '0;
                        hits_reg    <= '0;
                        state_reg   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Abort wins over any tick work in the same cycle.
                    if (stop) begin
                        state_reg <= ST_IDLE;
                        shreg_reg <= '0;
                        div_reg   <= '0;
                    end else begin
                        div_reg <= tick ? '0 : div_reg + DW'(1);
                        if (tick) begin
                            if (z && !(&hits_reg)) begin
                                hits_reg <= hits_reg + HIT_W'(1);
                            end
                            if (last_bit) begin
                                bit_cnt_reg <= '0;
                                if (repeat_en) begin
                                    shreg_reg <= pat_q_reg;
                                end else begin
                                    shreg_reg <= '0;
                                    state_reg <= ST_DONE;
                                end
                            end else begin
                                shreg_reg   <= shreg_shift;
                                bit_cnt_reg <= bit_cnt_reg + LW'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    div_reg   <= '0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    shreg_reg <= '0;
                    div_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_stream_gen.sv
// Bench for seq_stream_gen: directed pass table, multi-cycle corner sequences,
// and randomized traffic checked every cycle against a timing-based model.
module tb_seq_stream_gen;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       repeat_en = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
    logic       z = 1'b0;

    logic       x, tick_o, busy, done;
    logic [7:0] hits;
    logic       x3, tick3, busy3, done3;
    logic [2:0] hits3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_stream_gen #(.PATTERN_W(8), .TICK_DIV(4), .HIT_W(8)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .repeat_en(repeat_en),
        .pattern(pattern), .len(len), .z(z),
        .x(x), .tick_o(tick_o), .busy(busy), .done(done), .hits(hits)
    );

    seq_stream_gen #(.PATTERN_W(8), .TICK_DIV(4), .HIT_W(3)) dut3 (
        .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .repeat_en(repeat_en),
        .pattern(pattern), .len(len), .z(z),
        .x(x3), .tick_o(tick3), .busy(busy3), .done(done3), .hits(hits3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the stream is elapsed SEND time divided by the bit period.
    int         m_state = 0;   // 0 idle, 1 sending, 2 done
    int         m_t = 0;       // clks since the current run entered SEND
    logic [7:0] m_pat = 8'h00;
    int         m_n = 8;
    int         m_cnt = 0;     // unsaturated count of z=1 ticks

    always @(negedge clk) begin
        logic       e_x, e_tick, e_busy, e_done;
        logic [7:0] e_h8;
        logic [2:0] e_h3;
        int         bi;
        if (!clr_n) begin
            m_state = 0;
            m_t = 0;
            m_cnt = 0;
            check("reset_outputs", {x, tick_o, busy, done, x3, tick3, busy3, done3, hits, hits3}, 0);
        end else begin
            e_busy = (m_state == 1);
            e_done = (m_state == 2);
            e_tick = e_busy && (m_t % 4 == 3);
            bi = 0;
            e_x = 1'b0;
            if (e_busy) begin
                bi = (m_t / 4) % m_n;
                e_x = m_pat[7 - bi];
            end
            e_h8 = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
            e_h3 = (m_cnt > 7) ? 3'd7 : 3'(m_cnt);
            check("model", {x, tick_o, busy, done, x3, tick3, busy3, done3, hits, hits3},
                  {e_x, e_tick, e_busy, e_done, e_x, e_tick, e_busy, e_done, e_h8, e_h3});
            case (m_state)
                0: if (start && !stop) begin
                    m_state = 1;
                    m_t = 0;
                    m_pat = pattern;
                    m_n = (len == 0 || len > 8) ? 8 : int'(len);
                    m_cnt = 0;
                end
                1: if (stop) begin
                    m_state = 0;
                end else if (e_tick) begin
                    if (z) m_cnt++;
                    if (bi == m_n - 1 && !repeat_en) m_state = 2;
                    else m_t++;
                end else begin
                    m_t++;
                end
                default: m_state = 0;
            endcase
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [3:0] ln;
        logic       zv;
        logic [7:0] bits;   // expected x sequence, MSB first
        int         n;
        int         h8;
        int         h3;
    } pass_t;

    pass_t passes[6];

    task automatic run_pass(input pass_t p);
        pattern = p.pat; len = p.ln; z = p.zv; repeat_en = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 0; c < p.n * 4; c++) begin
            check("pass_x", x, p.bits[7 - c / 4]);
            check("pass_tick_busy", {tick_o, busy}, {(c % 4 == 3), 1'b1});
            next_cycle();
        end
        check("pass_done", {done, busy, x}, 3'b100);
        check("pass_hits", {hits, hits3}, {8'(p.h8), 3'(p.h3)});
        next_cycle();
        check("pass_after_done", {done, busy}, 2'b00);
    endtask

    initial begin
        passes[0] = '{8'b1011_0010, 4'd0, 1'b0, 8'b1011_0010, 8, 0, 0};
        passes[1] = '{8'hFF,        4'd8, 1'b1, 8'hFF,        8, 8, 7};
        passes[2] = '{8'b1100_0000, 4'd3, 1'b1, 8'b1100_0000, 3, 3, 3};
        passes[3] = '{8'hA5,        4'd9, 1'b0, 8'hA5,        8, 0, 0};
        passes[4] = '{8'h5A,        4'd1, 1'b1, 8'h00,        1, 1, 1};
        passes[5] = '{8'b0110_0000, 4'd2, 1'b1, 8'b0100_0000, 2, 2, 2};

        next_cycle();
        next_cycle();
        clr_n = 1'b1;
        check("reset_state", {x, tick_o, busy, done, hits}, 0);
        next_cycle();

        foreach (passes[i]) run_pass(passes[i]);

        // Reset in the middle of a pass
        pattern = 8'hFF; len = 4'd8; z = 1'b1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (10) next_cycle();
        check("pre_reset_hits", hits, 8'd2);
        clr_n = 1'b0;
        #1;
        check("async_reset", {x, busy, tick_o, hits}, 0);
        next_cycle();
        clr_n = 1'b1;
        check("reset_held", {x, busy, tick_o, done, hits}, 0);
        next_cycle();
        check("after_reset_idle", busy, 1'b0);

        // Repeat with len=3, stop after seven ticks
        pattern = 8'b1100_0000; len = 4'd3; repeat_en = 1'b1; z = 1'b1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 0; c < 28; c++) begin
            check("rep_x", x, (((c / 4) % 3) != 2));
            next_cycle();
        end
        check("rep_x_bit7", x, 1'b1);
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        check("stop_idle", {busy, done, x, hits}, {3'b000, 8'd7});
        next_cycle();
        check("stop_no_done", done, 1'b0);

        // Saturation over two repeated passes
        pattern = 8'hFF; len = 4'd8; repeat_en = 1'b1; z = 1'b1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (64) next_cycle();
        check("sat_busy", busy, 1'b1);
        check("sat_hits", {hits, hits3}, {8'd16, 3'd7});
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        check("sat_stop", {busy, done, hits}, {2'b00, 8'd16});

        // start held through DONE, pattern changed mid-pass
        pattern = 8'b1001_0000; len = 4'd4; repeat_en = 1'b0; z = 1'b0; start = 1'b1;
        next_cycle();
        for (int c = 0; c < 16; c++) begin
            if (c == 6) begin
                pattern = 8'hFF;
                len = 4'd1;
            end
            check("latched_x", x, (c / 4 == 0) || (c / 4 == 3));
            next_cycle();
        end
        check("held_done", {done, busy}, 2'b10);
        next_cycle();
        check("held_idle", busy, 1'b0);
        next_cycle();
        check("held_restart", {busy, x}, 2'b11);
        start = 1'b0;
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        check("held_abort", busy, 1'b0);

        // stop coinciding with the last-bit tick
        pattern = 8'b1000_0000; len = 4'd2; repeat_en = 1'b0; z = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (7) next_cycle();
        check("lastbit_tick", {tick_o, busy}, 2'b11);
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        check("lastbit_stop", {busy, done}, 2'b00);
        next_cycle();
        check("lastbit_no_done", done, 1'b0);

        // stop in IDLE blocks start
        start = 1'b1; stop = 1'b1;
        next_cycle();
        check("idle_stop_blocks", busy, 1'b0);
        start = 1'b0; stop = 1'b0;
        next_cycle();

        // Randomized traffic; the model checks every cycle
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom % 4 == 0);
            stop      = ($urandom % 60 == 0);
            repeat_en = ($urandom % 2 == 0);
            pattern   = 8'($urandom);
            len       = 4'($urandom_range(0, 15));
            z         = stop ? 1'b0 : 1'($urandom);
            clr_n     = ($urandom % 800 != 0);
            next_cycle();
        end
        clr_n = 1'b1;
        start = 1'b0; stop = 1'b0;
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
